// File: rtl/psum_accumulator_if.sv
// Bundled job-config, psum input and result-output signals for psum_accumulator.
// master drives the job and consumes results; slave is the accumulator.
interface psum_accumulator_if;
    logic         start;
    logic [7:0]   acc_len;
    logic [3:0]   weight_width;
    logic         signed_mode;
    logic         psum_valid;
    logic [51:0]  psum;
    logic         psum_ready;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_data;
    logic         busy;
    logic         cfg_err;
    logic         sat;

    modport master (
        output start, acc_len, weight_width, signed_mode, psum_valid, psum, out_ready,
        input  psum_ready, out_valid, out_data, busy, cfg_err, sat
    );

    modport slave (
        input  start, acc_len, weight_width, signed_mode, psum_valid, psum, out_ready,
        output psum_ready, out_valid, out_data, busy, cfg_err, sat
    );
endinterface

// File: rtl/psum_accumulator.sv
// Four-lane partial-sum accumulator: unpacks each psum word per weight width and sums acc_len beats.
// Define PSUM_ACC_SAT_EN for saturating lane adds (sets sticky sat); otherwise adds wrap.
module psum_accumulator (
    input  logic               clk,
    input  logic               rst_n,
    psum_accumulator_if.slave  bus
);
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ACCUM = 2'd1;
    localparam logic [1:0] DRAIN = 2'd2;

    logic [1:0] state_reg, state_next;
    logic [7:0] len_reg, cnt_reg;
    logic [3:0] width_reg;
    logic       signed_reg;
    logic       cfg_err_reg;
    logic       start_accept, beat_accept, last_beat, width_legal;
    logic       mode2, mode4;

    assign start_accept = (state_reg == IDLE) && bus.start;
    assign beat_accept  = (state_reg == ACCUM) && bus.psum_valid;
    // len_reg == 0 wraps to 255 here, so a zero length naturally runs 256 beats
    assign last_beat    = beat_accept && (cnt_reg == len_reg - 8'd1);
    assign width_legal  = (bus.weight_width == 4'd2) || (bus.weight_width == 4'd4) ||
                          (bus.weight_width == 4'd8);
    assign mode2        = (width_reg == 4'd2);
    assign mode4        = (width_reg == 4'd4);

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (bus.start) state_next = ACCUM;
            ACCUM:   if (last_beat) state_next = DRAIN;
            DRAIN:   if (bus.out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= IDLE;
            len_reg     <= '0;
            cnt_reg     <= '0;
            width_reg   <= '0;
            signed_reg  <= 1'b0;
            cfg_err_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            if (start_accept) begin
                len_reg     <= bus.acc_len;
                cnt_reg     <= '0;
                width_reg   <= width_legal ? bus.weight_width : 4'd8;
                signed_reg  <= bus.signed_mode;
                cfg_err_reg <= !width_legal;
            end else if (beat_accept) begin
                cnt_reg <= cnt_reg + 8'd1;
            end
        end
    end

`ifdef PSUM_ACC_SAT_EN
    logic [3:0] clamp;
    logic       sat_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sat_reg <= 1'b0;
        end else if (start_accept) begin
            sat_reg <= 1'b0;
        end else if (beat_accept && (|clamp)) begin
            sat_reg <= 1'b1;
        end
    end
    assign bus.sat = sat_reg;
`else
    assign bus.sat = 1'b0;
`endif

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            logic [31:0] ext13, ext26, ext32, lane_ext, sum_next, acc_reg;

            assign ext13 = {{19{signed_reg & bus.psum[13*gi+12]}}, bus.psum[13*gi+12 -: 13]};
            if (gi < 2) begin : g_w26
                assign ext26 = {{6{signed_reg & bus.psum[26*gi+25]}}, bus.psum[26*gi+25 -: 26]};
            end else begin : g_w26_off
                assign ext26 = '0;
            end
            if (gi == 0) begin : g_w32
                assign ext32 = bus.psum[31:0];
            end else begin : g_w32_off
                assign ext32 = '0;
            end

            always_comb begin
                lane_ext = ext32;
                if (mode2) begin
                    lane_ext = ext13;
                end else if (mode4) begin
                    lane_ext = ext26;
                end
            end

`ifdef PSUM_ACC_SAT_EN
            logic [32:0] sum_wide;
            logic        ovf;
            assign sum_wide = {1'b0, acc_reg} + {1'b0, lane_ext};
            always_comb begin
                ovf      = 1'b0;
                sum_next = sum_wide[31:0];
                if (signed_reg) begin
                    // overflow only when both operands share a sign the result lost
                    if ((acc_reg[31] == lane_ext[31]) && (sum_wide[31] != acc_reg[31])) begin
                        ovf      = 1'b1;
                        sum_next = acc_reg[31] ? 32'h8000_0000 : 32'h7FFF_FFFF;
                    end
                end else if (sum_wide[32]) begin
                    ovf      = 1'b1;
                    sum_next = 32'hFFFF_FFFF;
                end
            end
            assign clamp[gi] = ovf;
`else
            assign sum_next = acc_reg + lane_ext;
`endif

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    acc_reg <= '0;
                end else if (start_accept) begin
                    acc_reg <= '0;
                end else if (beat_accept) begin
                    acc_reg <= sum_next;
                end
            end

            assign bus.out_data[32*gi +: 32] = acc_reg;
        end
    endgenerate

    assign bus.psum_ready = (state_reg == ACCUM);
    assign bus.out_valid  = (state_reg == DRAIN);
    assign bus.busy       = (state_reg != IDLE);
    assign bus.cfg_err    = cfg_err_reg;
endmodule

// File: tb/tb_psum_accumulator.sv
// Directed-vector bench for psum_accumulator; expected values are hand-computed constants.
module tb_psum_accumulator;
    logic clk;
    logic rst_n;
    int   vectors;
    int   miscompares;

    psum_accumulator_if bus ();

    psum_accumulator dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
        $display("vector %0d %s obs=%0h exp=%0h", vectors, tag, obs, exp);
    endtask

    task automatic start_job(input logic [7:0] len, input logic [3:0] ww, input logic sgn);
        bus.acc_len      = len;
        bus.weight_width = ww;
        bus.signed_mode  = sgn;
        bus.start        = 1'b1;
        tick();
        bus.start        = 1'b0;
    endtask

    task automatic beat(input logic [51:0] d);
        bus.psum       = d;
        bus.psum_valid = 1'b1;
        tick();
        bus.psum_valid = 1'b0;
    endtask

    task automatic drain();
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
    endtask

    initial begin
        logic [127:0] held;
        vectors     = 0;
        miscompares = 0;
        bus.start        = 1'b0;
        bus.acc_len      = '0;
        bus.weight_width = '0;
        bus.signed_mode  = 1'b0;
        bus.psum_valid   = 1'b0;
        bus.psum         = '0;
        bus.out_ready    = 1'b0;
        rst_n = 1'b0;
        tick();
        tick();
        check("rst_out_data",   bus.out_data,   128'd0);
        check("rst_out_valid",  bus.out_valid,  128'd0);
        check("rst_psum_ready", bus.psum_ready, 128'd0);
        check("rst_busy",       bus.busy,       128'd0);
        check("rst_cfg_err",    bus.cfg_err,    128'd0);
        check("rst_sat",        bus.sat,        128'd0);
        rst_n = 1'b1;
        tick();

        // mode 2, unsigned, two beats of lanes {0,3,6,9}
        start_job(8'd2, 4'd2, 1'b0);
        check("m2_busy",       bus.busy,       128'd1);
        check("m2_psum_ready", bus.psum_ready, 128'd1);
        beat((52'd9 << 39) | (52'd6 << 26) | (52'd3 << 13));
        check("m2_valid_beat1", bus.out_valid, 128'd0);
        beat((52'd9 << 39) | (52'd6 << 26) | (52'd3 << 13));
        check("m2_valid_beat2", bus.out_valid, 128'd1);
        check("m2_data", bus.out_data, {32'd18, 32'd12, 32'd6, 32'd0});
        check("m2_ready_drain", bus.psum_ready, 128'd0);
        drain();
        check("m2_valid_after", bus.out_valid, 128'd0);
        check("m2_busy_after",  bus.busy,      128'd0);

        // psum_valid while idle must not disturb state or data
        bus.psum = 52'd7;
        bus.psum_valid = 1'b1;
        tick();
        tick();
        bus.psum_valid = 1'b0;
        check("idle_busy", bus.busy, 128'd0);
        check("idle_data", bus.out_data, {32'd18, 32'd12, 32'd6, 32'd0});

        // mode 4, unsigned, single beat of lanes {78,24}, then stalled drain
        start_job(8'd1, 4'd4, 1'b0);
        beat((52'd24 << 26) | 52'd78);
        check("m4_valid", bus.out_valid, 128'd1);
        check("m4_data",  bus.out_data, {32'd0, 32'd0, 32'd24, 32'd78});
        bus.psum = 52'hA_BCDE_F012_3456;
        bus.psum_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("stall_data",  bus.out_data, {32'd0, 32'd0, 32'd24, 32'd78});
            check("stall_valid", bus.out_valid, 128'd1);
            check("stall_ready", bus.psum_ready, 128'd0);
        end
        bus.psum_valid = 1'b0;
        // start raised in the handshake cycle is ignored
        bus.start = 1'b1;
        drain();
        bus.start = 1'b0;
        check("hs_valid_after", bus.out_valid, 128'd0);
        check("hs_start_ignored", bus.busy, 128'd0);

        // mode 8 via illegal width 5, signed, -1 three times with a gap
        start_job(8'd3, 4'd5, 1'b1);
        check("m8_cfg_err", bus.cfg_err, 128'd1);
        beat(52'hF_FFFF_FFFF_FFFF);
        tick();
        beat(52'hF_FFFF_FFFF_FFFF);
        check("m8_valid_gap", bus.out_valid, 128'd0);
        beat(52'hF_FFFF_FFFF_FFFF);
        check("m8_valid", bus.out_valid, 128'd1);
        check("m8_data",  bus.out_data, {96'd0, 32'hFFFF_FFFD});
        drain();

        // mode 2 signed: every lane 13'h1FFF sign-extends to -1; cfg_err clears
        start_job(8'd1, 4'd2, 1'b1);
        check("m2s_cfg_err", bus.cfg_err, 128'd0);
        beat(52'hF_FFFF_FFFF_FFFF);
        check("m2s_data", bus.out_data, {4{32'hFFFF_FFFF}});
        drain();

        // signed overflow: saturate or wrap depending on build
        start_job(8'd2, 4'd8, 1'b1);
        beat(52'h0_0000_7FFF_FFFF);
        beat(52'd1);
`ifdef PSUM_ACC_SAT_EN
        check("ovf_data", bus.out_data, {96'd0, 32'h7FFF_FFFF});
        check("ovf_sat",  bus.sat, 128'd1);
`else
        check("ovf_data", bus.out_data, {96'd0, 32'h8000_0000});
        check("ovf_sat",  bus.sat, 128'd0);
`endif
        drain();

        // acc_len 0 runs 256 beats
        start_job(8'd0, 4'd8, 1'b0);
        bus.psum = 52'd1;
        bus.psum_valid = 1'b1;
        repeat (255) tick();
        check("len0_valid_255", bus.out_valid, 128'd0);
        check("len0_ready_255", bus.psum_ready, 128'd1);
        tick();
        bus.psum_valid = 1'b0;
        check("len0_valid_256", bus.out_valid, 128'd1);
        check("len0_data", bus.out_data, {96'd0, 32'd256});
        drain();

        // asynchronous reset after 1 of 4 beats aborts the job
        start_job(8'd4, 4'd3, 1'b0);
        beat(52'd5);
        #2 rst_n = 1'b0;
        #1;
        check("arst_data",  bus.out_data,   128'd0);
        check("arst_busy",  bus.busy,       128'd0);
        check("arst_ready", bus.psum_ready, 128'd0);
        check("arst_valid", bus.out_valid,  128'd0);
        check("arst_cfg",   bus.cfg_err,    128'd0);
        @(negedge clk);
        rst_n = 1'b1;
        bus.psum = 52'd5;
        bus.psum_valid = 1'b1;
        repeat (4) tick();
        bus.psum_valid = 1'b0;
        check("post_rst_valid", bus.out_valid, 128'd0);
        check("post_rst_busy",  bus.busy,      128'd0);
        start_job(8'd1, 4'd8, 1'b0);
        beat(52'd5);
        check("new_job_valid", bus.out_valid, 128'd1);
        check("new_job_data",  bus.out_data, {96'd0, 32'd5});
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
